button_event: RTL

- Consumer end of the debounced-button path in the synth.
- Takes one clean (already debounced, same-clock) button level and turns it into single-cycle events: press, release, long-press and auto-repeat, plus a held level.
- Drives note triggers and the UI parameter step logic, so that downstream logic never edge-detects raw levels itself.

---
 rtl/button_event.sv | 126 ++++++++++++
 1 files changed

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// button_event: debounced button level -> press/release/long-press/repeat
//   events plus a held level. Optional macro: BUTTON_EVENT_REPEAT_EN.
// Revision: 1.0
// ============================================================================
module button_event #(
  parameter int CLK_FREQ_KHZ = 100_000,
  parameter int LONG_MS      = 500,
  parameter int REPEAT_MS    = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press,
  output logic release_evt,  // "release" is a reserved word in SystemVerilog
  output logic long_press,
  output logic rpt,
  output logic held
);

  localparam logic [63:0] LONG_TICKS_64   = 64'(CLK_FREQ_KHZ) * 64'(LONG_MS);
  localparam logic [63:0] REPEAT_TICKS_64 = 64'(CLK_FREQ_KHZ) * 64'(REPEAT_MS);
  localparam logic [31:0] LONG_LAST       = LONG_TICKS_64[31:0] - 32'd1;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [31:0] REPEAT_LAST     = REPEAT_TICKS_64[31:0] - 32'd1;
`endif

  generate
    if (LONG_TICKS_64 < 64'd1 || LONG_TICKS_64 > 64'hFFFF_FFFF) begin : g_long_range_err
      $error("button_event: LONG_TICKS must be in 1..2^32-1");
    end
    if (REPEAT_TICKS_64 < 64'd1 || REPEAT_TICKS_64 > 64'hFFFF_FFFF) begin : g_repeat_range_err
      $error("button_event: REPEAT_TICKS must be in 1..2^32-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_count;
  logic        r_btn_d;
  logic        w_rise;
  logic        w_fall;

  assign w_rise = btn & ~r_btn_d;
  assign w_fall = ~btn & r_btn_d;

`ifndef BUTTON_EVENT_REPEAT_EN
  assign rpt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= 32'd0;
      r_btn_d     <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      held        <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rpt         <= 1'b0;
`endif
    end else begin
      r_btn_d     <= btn;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rpt         <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_PRESSED;
            r_count <= 32'd0;
            press   <= 1'b1;
            held    <= 1'b1;
          end
        end
        S_PRESSED: begin
          // A fall on the threshold edge takes priority over long_press.
          if (w_fall) begin
            r_state     <= S_IDLE;
            r_count     <= 32'd0;
            release_evt <= 1'b1;
            held        <= 1'b0;
          end else if (r_count == LONG_LAST) begin
            r_state    <= S_REPEAT;
            r_count    <= 32'd0;
            long_press <= 1'b1;
          end else begin
            r_count <= r_count + 32'd1;
          end
        end
        S_REPEAT: begin
          if (w_fall) begin
            r_state     <= S_IDLE;
            r_count     <= 32'd0;
            release_evt <= 1'b1;
            held        <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
          end else if (r_count == REPEAT_LAST) begin
            r_count <= 32'd0;
            rpt     <= 1'b1;
          end else begin
            r_count <= r_count + 32'd1;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= 32'd0;
          held    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
